note_duration_player: RTL and testbench

//  Consumer end of the song-reader note interface. It accepts one-cycle new_note

---
 rtl/note_duration_player_pkg.sv | 28 ++
 rtl/note_duration_player_if.sv | 22 ++
 rtl/note_duration_player_note_fifo.sv | 58 +++++
 rtl/note_duration_player.sv | 131 +++++++++++++
 tb/tb_note_duration_player.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_duration_player_pkg.sv
// Shared widths, state encoding and note record for the song-reader / player pair.
// The song reader reuses the same widths so both ends of the note interface agree.
package note_duration_player_pkg;

   localparam int NOTE_W  = 6;
   localparam int DUR_W   = 6;
   localparam int META_W  = 3;
   localparam int ENTRY_W = NOTE_W + DUR_W + META_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_PLAY = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
      logic [META_W-1:0] meta;
   } note_entry_t;

   // Note index 0 is a rest: it occupies time but never drives the sine generator.
   function automatic logic is_rest(input logic [NOTE_W-1:0] note);
      return (note == '0);
   endfunction

endpackage

// File: rtl/note_duration_player_if.sv
// Note hand-off between the song reader (master) and the duration player (slave).
// new_note qualifies note/duration/metadata for one cycle; note_done flows back.
interface note_duration_player_if;
   import note_duration_player_pkg::*;

   logic              new_note;
   logic [NOTE_W-1:0] note;
   logic [DUR_W-1:0]  duration;
   logic [META_W-1:0] metadata;
   logic              note_done;

   modport master (
      output new_note, note, duration, metadata,
      input  note_done
   );

   modport slave (
      input  new_note, note, duration, metadata,
      output note_done
   );

endinterface

// File: rtl/note_duration_player_note_fifo.sv
// Small synchronous holding FIFO for queued notes; synchronous active-low reset,
// synchronous clear, push accepted when full only if a pop happens the same cycle.
module note_fifo
   import note_duration_player_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_dout    = r_mem[r_rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!reset || i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset && !i_clear && w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/note_duration_player.sv
// Consumer end of the note interface: queues notes, plays each for `duration` beats,
// and drives the frequency-lookup / sine-generator front end.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for a queued note while play=1; pops and latches it
//  S_LOAD | one cycle, load_note pulse so the sine generator reloads
//  S_PLAY | counting beats down while play=1; pause holds the count
//  S_DONE | one cycle, note_done pulse back to the song reader
module note_duration_player
   import note_duration_player_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_play,
   input  logic                  i_flush,
   input  logic                  i_beat,
   note_duration_player_if.slave nif,
   output logic                  o_load_note,
   output logic                  o_sound_en,
   output logic [NOTE_W-1:0]     o_cur_note,
   output logic [META_W-1:0]     o_cur_meta,
   output logic                  o_busy,
   output logic                  o_fifo_full,
   output logic                  o_overflow
);

   state_t            r_state;
   logic [DUR_W-1:0]  r_beats_left;
   logic [NOTE_W-1:0] r_cur_note;
   logic [META_W-1:0] r_cur_meta;
   logic              r_sound_en;
   logic              r_overflow;

   logic              w_full;
   logic              w_empty;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_last_beat;
   logic [ENTRY_W-1:0] w_din;
   logic [ENTRY_W-1:0] w_dout;
   note_entry_t       w_head;

   assign w_din   = {nif.note, nif.duration, nif.metadata};
   assign w_head  = note_entry_t'(w_dout);
   assign w_pop   = (r_state == S_IDLE) & ~w_empty & i_play & ~i_flush;
   assign w_push  = nif.new_note & ~i_flush;
   assign w_drop  = w_push & w_full & ~w_pop;

   assign w_last_beat = i_beat & i_play & (r_beats_left == DUR_W'(1));

   note_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clear (i_flush),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_din),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_beats_left <= '0;
         r_cur_note   <= '0;
         r_cur_meta   <= '0;
         r_sound_en   <= 1'b0;
         r_overflow   <= 1'b0;
      end else if (i_flush) begin
         // cur_note/cur_meta are deliberately kept so the front end holds its pitch
         r_state      <= S_IDLE;
         r_beats_left <= '0;
         r_sound_en   <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_drop) r_overflow <= 1'b1;
         case (r_state)
            S_IDLE: begin
               r_sound_en <= 1'b0;
               if (w_pop) begin
                  r_cur_note   <= w_head.note;
                  r_cur_meta   <= w_head.meta;
                  r_beats_left <= w_head.dur;
                  r_state      <= (w_head.dur == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               r_sound_en <= ~is_rest(r_cur_note) & i_play;
               r_state    <= S_PLAY;
            end
            S_PLAY: begin
               r_sound_en <= ~is_rest(r_cur_note) & i_play;
               if (i_beat && i_play) begin
                  r_beats_left <= r_beats_left - DUR_W'(1);
               end
               if (w_last_beat) begin
                  r_sound_en <= 1'b0;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               r_sound_en <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_sound_en <= 1'b0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

   assign o_load_note   = (r_state == S_LOAD);
   assign nif.note_done = (r_state == S_DONE);
   assign o_sound_en    = r_sound_en;
   assign o_cur_note    = r_cur_note;
   assign o_cur_meta    = r_cur_meta;
   assign o_busy        = (r_state != S_IDLE) | ~w_empty;
   assign o_fifo_full   = w_full;
   assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_note_duration_player.sv
// Bench for note_duration_player: directed scenarios plus random traffic, every
// cycle compared against a queue-based behavioural model of the player.
module tb_note_duration_player;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       t_reset;
   logic       t_play;
   logic       t_flush;
   logic       t_beat;
   logic       o_load_note;
   logic       o_sound_en;
   logic [5:0] o_cur_note;
   logic [2:0] o_cur_meta;
   logic       o_busy;
   logic       o_fifo_full;
   logic       o_overflow;

   note_duration_player_if nif ();

   note_duration_player #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (t_reset),
      .i_play      (t_play),
      .i_flush     (t_flush),
      .i_beat      (t_beat),
      .nif         (nif),
      .o_load_note (o_load_note),
      .o_sound_en  (o_sound_en),
      .o_cur_note  (o_cur_note),
      .o_cur_meta  (o_cur_meta),
      .o_busy      (o_busy),
      .o_fifo_full (o_fifo_full),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: a queue of pending notes and a description of the note in hand.
   typedef struct { int note; int dur; int meta; } mnote_t;
   mnote_t m_q[$];
   bit m_loading, m_playing, m_retiring, m_snd, m_ovf;
   int m_left, m_note, m_meta;

   task automatic ref_step();
      mnote_t e;
      bit in_hand;
      if (!t_reset) begin
         m_q.delete();
         m_loading = 0; m_playing = 0; m_retiring = 0;
         m_left = 0; m_note = 0; m_meta = 0; m_snd = 0; m_ovf = 0;
         return;
      end
      if (t_flush) begin
         m_q.delete();
         m_loading = 0; m_playing = 0; m_retiring = 0; m_snd = 0; m_ovf = 0;
         return;
      end
      in_hand = m_loading || m_playing || m_retiring;
      if (m_retiring) begin
         m_retiring = 0;
         m_snd = 0;
      end else if (m_loading) begin
         m_loading = 0;
         m_playing = 1;
         m_snd = (m_note != 0) && t_play;
      end else if (m_playing) begin
         if (t_beat && t_play) begin
            m_left = m_left - 1;
            m_snd  = (m_note != 0);
            if (m_left == 0) begin
               m_playing = 0; m_retiring = 1; m_snd = 0;
            end
         end else begin
            m_snd = (m_note != 0) && t_play;
         end
      end else begin
         m_snd = 0;
      end
      if (!in_hand && t_play && m_q.size() > 0) begin
         e = m_q.pop_front();
         m_note = e.note; m_meta = e.meta; m_left = e.dur;
         if (e.dur == 0) m_retiring = 1;
         else            m_loading  = 1;
      end
      if (nif.new_note) begin
         if (m_q.size() < DEPTH) m_q.push_back('{int'(nif.note), int'(nif.duration), int'(nif.metadata)});
         else                    m_ovf = 1;
      end
   endtask

   task automatic check_all();
      chk("load_note", o_load_note,   m_loading);
      chk("note_done", nif.note_done, m_retiring);
      chk("sound_en",  o_sound_en,    m_snd);
      chk("busy",      o_busy,        (m_loading || m_playing || m_retiring || m_q.size() > 0));
      chk("fifo_full", o_fifo_full,   (m_q.size() == DEPTH));
      chk("overflow",  o_overflow,    m_ovf);
      chk("cur_note",  o_cur_note,    m_note);
      chk("cur_meta",  o_cur_meta,    m_meta);
   endtask

   int done_cnt;
   int done_notes[$];

   task automatic tick();
      @(posedge clk);
      ref_step();
      #1;
      check_all();
      if (nif.note_done === 1'b1) begin
         done_cnt++;
         done_notes.push_back(int'(o_cur_note));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic push_note(input logic [5:0] n, input logic [5:0] d, input logic [2:0] m);
      nif.new_note = 1'b1; nif.note = n; nif.duration = d; nif.metadata = m;
      tick();
      nif.new_note = 1'b0;
   endtask

   task automatic beat_tick();
      t_beat = 1'b1;
      tick();
      t_beat = 1'b0;
   endtask

   task automatic do_flush();
      t_flush = 1'b1;
      tick();
      t_flush = 1'b0;
   endtask

   initial begin
      t_reset = 1'b0; t_play = 1'b0; t_flush = 1'b0; t_beat = 1'b0;
      nif.new_note = 1'b0; nif.note = '0; nif.duration = '0; nif.metadata = '0;
      done_cnt = 0;

      // 1: reset with random inputs
      for (int i = 0; i < 5; i++) begin
         t_play = 1'($urandom); t_beat = 1'($urandom); t_flush = 1'($urandom);
         nif.new_note = 1'($urandom); nif.note = 6'($urandom);
         nif.duration = 6'($urandom); nif.metadata = 3'($urandom);
         tick();
      end
      chk("rst_busy", o_busy, 0);
      t_reset = 1'b1; t_play = 1'b1; t_flush = 1'b0; t_beat = 1'b0; nif.new_note = 1'b0;
      idle(2);

      // 2: single note 37/3/5
      done_cnt = 0;
      push_note(6'd37, 6'd3, 3'd5);
      tick();
      chk("t2_load", o_load_note, 1);
      chk("t2_note", o_cur_note, 37);
      chk("t2_meta", o_cur_meta, 5);
      tick();
      chk("t2_snd", o_sound_en, 1);
      beat_tick(); idle(1); beat_tick(); idle(1);
      chk("t2_early_done", done_cnt, 0);
      beat_tick();
      chk("t2_done", nif.note_done, 1);
      idle(2);

      // 3: four back-to-back notes into a 2-deep FIFO
      done_cnt = 0; done_notes.delete();
      push_note(6'd10, 6'd1, 3'd1);
      push_note(6'd20, 6'd1, 3'd2);
      push_note(6'd30, 6'd1, 3'd3);
      push_note(6'd40, 6'd1, 3'd4);
      chk("t3_ovf", o_overflow, 1);
      for (int i = 0; i < 12; i++) begin beat_tick(); idle(1); end
      chk("t3_count", done_cnt, 3);
      if (done_notes.size() == 3) begin
         chk("t3_first", done_notes[0], 10);
         chk("t3_second", done_notes[1], 20);
         chk("t3_third", done_notes[2], 30);
      end else begin
         chk("t3_order_len", done_notes.size(), 3);
      end
      do_flush();
      chk("t3_ovf_clr", o_overflow, 0);

      // 4: pause in the middle of a 4-beat note
      done_cnt = 0;
      push_note(6'd7, 6'd4, 3'd6);
      idle(2);
      beat_tick();
      t_play = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat_tick();
         chk("t4_paused_snd", o_sound_en, 0);
         idle(1);
      end
      t_play = 1'b1;
      idle(1);
      chk("t4_resume_snd", o_sound_en, 1);
      beat_tick(); idle(1); beat_tick(); idle(1);
      chk("t4_early_done", done_cnt, 0);
      beat_tick();
      chk("t4_done", nif.note_done, 1);
      idle(2);

      // 5: zero-length note, then a rest
      push_note(6'd12, 6'd0, 3'd2);
      tick();
      chk("t5_zero_done", nif.note_done, 1);
      chk("t5_zero_load", o_load_note, 0);
      chk("t5_zero_snd", o_sound_en, 0);
      idle(2);
      done_cnt = 0;
      push_note(6'd0, 6'd2, 3'd0);
      tick();
      chk("t5_rest_load", o_load_note, 1);
      tick();
      chk("t5_rest_snd", o_sound_en, 0);
      beat_tick(); idle(1); beat_tick();
      chk("t5_rest_done", nif.note_done, 1);
      idle(2);

      // 6: flush mid-PLAY with two queued notes, then the same with reset
      done_cnt = 0;
      push_note(6'd5, 6'd6, 3'd1);
      push_note(6'd9, 6'd2, 3'd2);
      push_note(6'd11, 6'd2, 3'd3);
      idle(1); beat_tick();
      chk("t6_full", o_fifo_full, 1);
      do_flush();
      chk("t6_busy", o_busy, 0);
      chk("t6_snd", o_sound_en, 0);
      chk("t6_keep_note", o_cur_note, 5);
      idle(4);
      chk("t6_no_done", done_cnt, 0);
      push_note(6'd5, 6'd6, 3'd1);
      push_note(6'd9, 6'd2, 3'd2);
      push_note(6'd11, 6'd2, 3'd3);
      idle(1); beat_tick();
      t_reset = 1'b0;
      tick();
      t_reset = 1'b1;
      chk("t6_rst_busy", o_busy, 0);
      chk("t6_rst_note", o_cur_note, 0);
      chk("t6_rst_full", o_fifo_full, 0);
      idle(2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         t_reset = ($urandom_range(0, 199) != 0);
         t_flush = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 19) == 0) t_play = ~t_play;
         t_beat = ($urandom_range(0, 2) == 0);
         nif.new_note = ($urandom_range(0, 3) == 0);
         nif.note     = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         nif.duration = 6'($urandom_range(0, 4));
         nif.metadata = 3'($urandom);
         tick();
      end
      t_reset = 1'b1; t_flush = 1'b0; t_beat = 1'b0; nif.new_note = 1'b0;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
